// File: rtl/spi_flash_req_bridge.sv
// rtl/spi_flash_req_bridge.sv - CPU request FIFO and one-at-a-time issue bridge to the SPI flash controller
// Optional WAIT watchdog: define SPI_FLASH_BRIDGE_TIMEOUT_EN.
module spi_flash_req_bridge #(
    parameter int REQ_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_quad,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_write,
    output logic        resp_err,
    output logic        flash_en,
    output logic        flash_write,
    output logic [3:0]  flash_quad_io,
    output logic [23:0] flash_addr,
    output logic [31:0] flash_data_in,
    input  logic [31:0] flash_data_out,
    input  logic        flash_ready,
    output logic [2:0]  pending
);
    localparam int PTR_W   = $clog2(REQ_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 61;

    // Unsupported parameter values leave this marker block in the hierarchy.
    if (REQ_DEPTH < 2 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_unsupported_params
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state;
    logic [ENTRY_W-1:0] fifo_mem [REQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    assign full      = (count == CNT_W'(REQ_DEPTH));
    assign empty     = (count == '0);
    assign req_ready = reset && !full;
    assign push      = req_valid && req_ready;
    // A new command is only started once the previous response has been taken.
    assign pop       = (state == ST_IDLE) && !empty && flash_ready && !resp_valid;
    assign head      = fifo_mem[rd_ptr];

    always_comb begin
        if (32'(count) > 32'd7) begin
            pending = 3'd7;
        end else begin
            pending = 3'(count);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_write, req_quad, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SPI_FLASH_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;
    logic        resp_err_q;
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            flash_en      <= 1'b0;
            flash_write   <= 1'b0;
            flash_quad_io <= '0;
            flash_addr    <= '0;
            flash_data_in <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_write    <= 1'b0;
`ifdef SPI_FLASH_BRIDGE_TIMEOUT_EN
            wait_cnt      <= '0;
            resp_err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        {flash_write, flash_quad_io, flash_addr, flash_data_in} <= head;
                        flash_en <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    flash_en <= 1'b0;
                    state    <= ST_ARM;
                end
                // The controller still shows the stale ready here; skip one cycle.
                ST_ARM: begin
`ifdef SPI_FLASH_BRIDGE_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (flash_ready) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= flash_write ? 32'd0 : flash_data_out;
                        resp_write <= flash_write;
`ifdef SPI_FLASH_BRIDGE_TIMEOUT_EN
                        resp_err_q <= 1'b0;
`endif
                        state      <= ST_RESP;
                    end
`ifdef SPI_FLASH_BRIDGE_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LIMIT) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'd0;
                        resp_write <= flash_write;
                        resp_err_q <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
`ifdef SPI_FLASH_BRIDGE_TIMEOUT_EN
                        resp_err_q <= 1'b0;
`endif
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    flash_en <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
